// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, widths and grant-side type for the shared ALU arbiter
package alu_pkg;

    localparam int ALU_CTRL_W = 3;
    localparam int ALU_DATA_W = 32;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHL = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SHR = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b111;

    // Idle drive value: ADD with zero operands keeps the ALU inputs quiet.
    localparam logic [ALU_CTRL_W-1:0] ALU_NOP = ALU_ADD;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_sel_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// rtl/alu_rsp_slot.sv - one captured ALU response held under a valid/ready handshake
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ready,
    input  logic [DATA_W-1:0] d_result,
    input  logic              d_zero,
    input  logic              d_sign,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              sign
);

    // A load wins over a drain so a slot emptied this cycle can be refilled at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            sign   <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= d_result;
            zero   <= d_zero;
            sign   <= d_sign;
        end else if (ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CTRL_W = ALU_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_srcA,
    input  logic [DATA_W-1:0] req0_srcB,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_srcA,
    input  logic [DATA_W-1:0] req1_srcB,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_sign,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_sign,
    output logic [DATA_W-1:0] alu_srcA,
    output logic [DATA_W-1:0] alu_srcB,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_sign,
    output logic [CNT_W-1:0]  contention_cnt
);

    logic       elig0, elig1;
    logic       grant0, grant1;
    grant_sel_e last_grant;

    // Nothing is accepted while reset is held, so no request is lost to a discarded slot.
    assign elig0 = ~rst & req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = ~rst & req1_valid & (~rsp1_valid | rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = (last_grant == GRANT_REQ1);
            grant1 = (last_grant == GRANT_REQ0);
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_srcA = '0;
        alu_srcB = '0;
        alu_ctrl = CTRL_W'(ALU_NOP);
        if (grant0) begin
            alu_srcA = req0_srcA;
            alu_srcB = req0_srcB;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_srcA = req1_srcA;
            alu_srcB = req1_srcB;
            alu_ctrl = req1_ctrl;
        end
    end

    // Reset value favours req0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_REQ1;
        end else if (grant0) begin
            last_grant <= GRANT_REQ0;
        end else if (grant1) begin
            last_grant <= GRANT_REQ1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contention_cnt <= '0;
        end else if (elig0 && elig1 && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

    alu_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .load     (grant0),
        .ready    (rsp0_ready),
        .d_result (alu_result),
        .d_zero   (alu_zero),
        .d_sign   (alu_sign),
        .valid    (rsp0_valid),
        .result   (rsp0_result),
        .zero     (rsp0_zero),
        .sign     (rsp0_sign)
    );

    alu_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .load     (grant1),
        .ready    (rsp1_ready),
        .d_result (alu_result),
        .d_zero   (alu_zero),
        .d_sign   (alu_sign),
        .valid    (rsp1_valid),
        .result   (rsp1_result),
        .zero     (rsp1_zero),
        .sign     (rsp1_sign)
    );

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with a behavioural ALU
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp0_sign, rsp1_zero, rsp1_sign;
    logic [31:0] alu_srcA, alu_srcB, alu_result;
    logic [2:0]  alu_ctrl;
    logic        alu_zero, alu_sign;
    logic [15:0] contention_cnt;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        s;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        s;
    } exp_t;

    vec_t v0, v1;
    exp_t q0[$], q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.DATA_W(32), .CTRL_W(3), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (v0.valid),
        .req0_ready     (req0_ready),
        .req0_srcA      (v0.a),
        .req0_srcB      (v0.b),
        .req0_ctrl      (v0.ctrl),
        .req1_valid     (v1.valid),
        .req1_ready     (req1_ready),
        .req1_srcA      (v1.a),
        .req1_srcB      (v1.b),
        .req1_ctrl      (v1.ctrl),
        .rsp0_valid     (rsp0_valid),
        .rsp0_ready     (rsp0_ready),
        .rsp0_result    (rsp0_result),
        .rsp0_zero      (rsp0_zero),
        .rsp0_sign      (rsp0_sign),
        .rsp1_valid     (rsp1_valid),
        .rsp1_ready     (rsp1_ready),
        .rsp1_result    (rsp1_result),
        .rsp1_zero      (rsp1_zero),
        .rsp1_sign      (rsp1_sign),
        .alu_srcA       (alu_srcA),
        .alu_srcB       (alu_srcB),
        .alu_ctrl       (alu_ctrl),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .alu_sign       (alu_sign),
        .contention_cnt (contention_cnt)
    );

    // Shared ALU: undefined opcodes produce zero, shifts use only the low five bits of srcB.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD: alu_result = alu_srcA + alu_srcB;
            ALU_SUB: alu_result = alu_srcA - alu_srcB;
            ALU_SHL: alu_result = alu_srcA << alu_srcB[4:0];
            ALU_SHR: alu_result = alu_srcA >> alu_srcB[4:0];
            ALU_XOR: alu_result = alu_srcA ^ alu_srcB;
            ALU_OR:  alu_result = alu_srcA | alu_srcB;
            ALU_AND: alu_result = alu_srcA & alu_srcB;
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
        alu_sign = alu_result[31];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic z, input logic s);
        vec_t v;
        v.valid = 1'b1;
        v.ctrl  = c;
        v.a     = a;
        v.b     = b;
        v.r     = r;
        v.z     = z;
        v.s     = s;
        return v;
    endfunction

    // Inputs change just after the rising edge; grants are judged mid-cycle.
    task automatic cyc(input bit eg0, input bit eg1);
        @(negedge clk);
        chk("grant0", req0_ready, eg0);
        chk("grant1", req1_ready, eg1);
        if (eg0) q0.push_back({v0.r, v0.z, v0.s});
        if (eg1) q1.push_back({v1.r, v1.z, v1.s});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: a held response must match the queue head every cycle; a consumed one pops it.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid) begin
                if (q0.size() == 0) chk("rsp0_unexpected", rsp0_valid, 1'b0);
                else begin
                    chk("rsp0_result", rsp0_result, q0[0].r);
                    chk("rsp0_zero", rsp0_zero, q0[0].z);
                    chk("rsp0_sign", rsp0_sign, q0[0].s);
                    if (rsp0_ready) void'(q0.pop_front());
                end
            end
            if (rsp1_valid) begin
                if (q1.size() == 0) chk("rsp1_unexpected", rsp1_valid, 1'b0);
                else begin
                    chk("rsp1_result", rsp1_result, q1[0].r);
                    chk("rsp1_zero", rsp1_zero, q1[0].z);
                    chk("rsp1_sign", rsp1_sign, q1[0].s);
                    if (rsp1_ready) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v0 = '0;
        v1 = '0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("reset_rsp1_valid", rsp1_valid, 1'b0);
        chk("reset_rsp0_result", rsp0_result, 32'h0);
        chk("reset_rsp1_zero", rsp1_zero, 1'b0);
        chk("reset_cnt", contention_cnt, 16'h0);
        chk("idle_alu_srcA", alu_srcA, 32'h0);
        chk("idle_alu_ctrl", alu_ctrl, 3'b000);
        rst = 1'b0;

        // Single request, response one edge later
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        v0 = mk(ALU_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
        cyc(1, 0);
        v0 = '0;
        chk("lat_rsp0_valid", rsp0_valid, 1'b1);
        chk("lat_rsp0_result", rsp0_result, 32'd8);
        cyc(0, 0);

        // Round-robin alternation from reset
        do_reset();
        v0 = mk(ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        v1 = mk(ALU_XOR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(k % 2 == 0, k % 2 == 1);
        chk("rr_cnt", contention_cnt, 16'd4);
        v0 = '0;
        v1 = '0;
        repeat (2) cyc(0, 0);
        chk("idle_cnt_hold", contention_cnt, 16'd4);

        // Back-pressure on rsp1 while req0 keeps flowing
        rsp1_ready = 1'b0;
        v1 = mk(ALU_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
        cyc(0, 1);
        v0 = mk(ALU_OR, 32'h10, 32'h01, 32'h11, 1'b0, 1'b0);
        repeat (3) cyc(1, 0);
        chk("hold_rsp1_valid", rsp1_valid, 1'b1);
        rsp1_ready = 1'b1;
        cyc(0, 1);
        v0 = '0;
        v1 = '0;
        cyc(0, 0);
        chk("hold_cnt", contention_cnt, 16'd5);

        // Negative result then back-to-back ANDs
        v0 = mk(ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        cyc(1, 0);
        v0 = mk(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
        cyc(1, 0);
        v0 = mk(ALU_AND, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        cyc(1, 0);
        v0 = mk(ALU_AND, 32'h0000_AAAA, 32'h0000_5555, 32'h0, 1'b1, 1'b0);
        cyc(1, 0);
        v0 = '0;

        // Unmasked shift amount and undefined opcode pass-through
        v1 = mk(ALU_SHL, 32'd1, 32'h24, 32'd16, 1'b0, 1'b0);
        #1;
        chk("shift_srcB_unmasked", alu_srcB, 32'h24);
        cyc(0, 1);
        v1 = mk(3'b011, 32'd5, 32'd9, 32'd0, 1'b1, 1'b0);
        #1;
        chk("undef_ctrl_fwd", alu_ctrl, 3'b011);
        cyc(0, 1);
        v1 = '0;
        repeat (2) cyc(0, 0);

        // Reset while both slots hold results and both requesters are valid
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        v0 = mk(ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
        cyc(1, 0);
        v1 = mk(ALU_ADD, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0);
        cyc(0, 1);
        chk("pre_rst_rsp0_valid", rsp0_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_rsp0_valid", rsp0_valid, 1'b0);
        chk("midrst_rsp1_valid", rsp1_valid, 1'b0);
        chk("midrst_cnt", contention_cnt, 16'h0);
        chk("midrst_req0_ready", req0_ready, 1'b0);
        q0.delete();
        q1.delete();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 0);
        cyc(0, 1);
        v0 = '0;
        v1 = '0;
        repeat (2) cyc(0, 0);

        // Saturation of the contention counter
        do_reset();
        v0 = mk(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        v1 = mk(ALU_AND, 32'd3, 32'd1, 32'd1, 1'b0, 1'b0);
        for (int k = 0; k < 65535; k++) cyc(k % 2 == 0, k % 2 == 1);
        chk("sat_cnt_reach", contention_cnt, 16'hFFFF);
        for (int k = 65535; k < 65541; k++) cyc(k % 2 == 0, k % 2 == 1);
        chk("sat_cnt_nowrap", contention_cnt, 16'hFFFF);
        v0 = '0;
        v1 = '0;
        repeat (2) cyc(0, 0);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
